// File: rtl/ean13_decoder.sv
// ean13_decoder: serial EAN-13 module stream -> 13 BCD digits (L/G/R lookup, parity-derived first digit).
// Define EAN13_CHECKSUM_EN to add the CHECK state with modulo-10 check-digit verification.
module ean13_decoder #(
  parameter int unsigned INVERT_MODULE = 0
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic        iModuleValid,
  input  logic        iModuleBit,
  output logic [51:0] oDataCode,
  output logic        oNewData,
  output logic        oError,
  output logic [1:0]  oErrCode,
  output logic        oBusy
);

  typedef enum logic [2:0] {IDLE, COLLECT, PARITY, CHECK, DONE} state_t;

  state_t      state, stateNext;
  logic [2:0]  modCnt;
  logic [3:0]  digCnt;
  logic [5:0]  shiftReg;
  logic [5:0]  parityBits;
  logic [3:0]  digitMem [13];

  function automatic logic [6:0] lPattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0001101;
      4'd1:    return 7'b0011001;
      4'd2:    return 7'b0010011;
      4'd3:    return 7'b0111101;
      4'd4:    return 7'b0100011;
      4'd5:    return 7'b0110001;
      4'd6:    return 7'b0101111;
      4'd7:    return 7'b0111011;
      4'd8:    return 7'b0110111;
      default: return 7'b0001011;
    endcase
  endfunction

  function automatic logic [6:0] reverse7(input logic [6:0] p);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = p[6-i];
    return r;
  endfunction

  // {valid, parity(G=1), digit}
  function automatic logic [5:0] decodeLeft(input logic [6:0] p);
    logic [5:0] res;
    res = 6'd0;
    for (int i = 0; i < 10; i++) begin
      if (p == lPattern(4'(i)))                 res = {2'b10, 4'(i)};
      else if (p == reverse7(~lPattern(4'(i)))) res = {2'b11, 4'(i)};
    end
    return res;
  endfunction

  function automatic logic [4:0] decodeRight(input logic [6:0] p);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 0; i < 10; i++)
      if (p == ~lPattern(4'(i))) res = {1'b1, 4'(i)};
    return res;
  endfunction

  // Parity bits with digit 1 in the MSB; returns {valid, firstDigit}
  function automatic logic [4:0] firstFromParity(input logic [5:0] pb);
    case (pb)
      6'b000000: return 5'h10;
      6'b001011: return 5'h11;
      6'b001101: return 5'h12;
      6'b001110: return 5'h13;
      6'b010011: return 5'h14;
      6'b011001: return 5'h15;
      6'b011100: return 5'h16;
      6'b010101: return 5'h17;
      6'b010110: return 5'h18;
      6'b011010: return 5'h19;
      default:   return 5'h00;
    endcase
  endfunction

  logic        bitIn, isLeft, patOk;
  logic [6:0]  pattern;
  logic [5:0]  leftRes;
  logic [4:0]  rightRes, firstRes;
  logic [3:0]  patDigit, headDigit;
  logic [51:0] packedCode;

  assign bitIn     = (INVERT_MODULE != 0) ? ~iModuleBit : iModuleBit;
  assign pattern   = {shiftReg, bitIn};
  assign leftRes   = decodeLeft(pattern);
  assign rightRes  = decodeRight(pattern);
  assign isLeft    = digCnt < 4'd6;
  assign patOk     = isLeft ? leftRes[5] : rightRes[4];
  assign patDigit  = isLeft ? leftRes[3:0] : rightRes[3:0];
  assign firstRes  = firstFromParity(parityBits);
  assign headDigit = (state == PARITY) ? firstRes[3:0] : digitMem[0];

  always_comb begin
    packedCode = '0;
    packedCode[51:48] = headDigit;
    for (int i = 1; i < 13; i++) packedCode[51-4*i -: 4] = digitMem[i];
  end

`ifdef EAN13_CHECKSUM_EN
  logic [3:0] chkIdx, acc, accNext, chkDigit;
  logic [5:0] weighted;

  function automatic logic [3:0] mod10(input logic [5:0] v);
    logic [5:0] t;
    t = v;
    for (int i = 0; i < 3; i++) if (t >= 6'd10) t = t - 6'd10;
    return 4'(t);
  endfunction

  assign chkDigit = digitMem[chkIdx];
  assign weighted = chkIdx[0] ? ({2'b00, chkDigit} + {1'b0, chkDigit, 1'b0}) : {2'b00, chkDigit};
  assign accNext  = mod10({2'b00, acc} + weighted);
`endif

  logic       doClear, doShift, doStore, doReject, doLoad;
  logic [1:0] rejCode;

  always_comb begin
    stateNext = state;
    doClear   = 1'b0;
    doShift   = 1'b0;
    doStore   = 1'b0;
    doReject  = 1'b0;
    doLoad    = 1'b0;
    rejCode   = 2'd0;
    if (iStart) begin
      stateNext = COLLECT;
      doClear   = 1'b1;
    end else if (iAbort && (state == COLLECT || state == PARITY || state == CHECK)) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: stateNext = IDLE;
        COLLECT: if (iModuleValid) begin
          doShift = 1'b1;
          if (modCnt == 3'd6) begin
            if (!patOk) begin
              doReject  = 1'b1;
              rejCode   = 2'd1;
              stateNext = IDLE;
            end else begin
              doStore = 1'b1;
              if (digCnt == 4'd11) stateNext = PARITY;
            end
          end
        end
        PARITY: if (!firstRes[4]) begin
          doReject  = 1'b1;
          rejCode   = 2'd2;
          stateNext = IDLE;
        end else begin
`ifdef EAN13_CHECKSUM_EN
          stateNext = CHECK;
`else
          stateNext = DONE;
          doLoad    = 1'b1;
`endif
        end
`ifdef EAN13_CHECKSUM_EN
        CHECK: if (chkIdx == 4'd12) begin
          if (accNext == 4'd0) begin
            stateNext = DONE;
            doLoad    = 1'b1;
          end else begin
            doReject  = 1'b1;
            rejCode   = 2'd3;
            stateNext = IDLE;
          end
        end
`endif
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Control and output registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      modCnt    <= 3'd0;
      digCnt    <= 4'd0;
      oDataCode <= '0;
      oNewData  <= 1'b0;
      oError    <= 1'b0;
      oErrCode  <= 2'd0;
      oBusy     <= 1'b0;
`ifdef EAN13_CHECKSUM_EN
      chkIdx    <= 4'd0;
`endif
    end else begin
      state    <= stateNext;
      oNewData <= doLoad;
      oError   <= doReject;
      oBusy    <= (stateNext == COLLECT) || (stateNext == PARITY) || (stateNext == CHECK);
      if (doReject) oErrCode  <= rejCode;
      if (doLoad)   oDataCode <= packedCode;
      if (doClear) begin
        modCnt <= 3'd0;
        digCnt <= 4'd0;
      end else if (doShift) begin
        modCnt <= (modCnt == 3'd6) ? 3'd0 : modCnt + 3'd1;
        if (doStore) digCnt <= digCnt + 4'd1;
      end
`ifdef EAN13_CHECKSUM_EN
      if (state == PARITY)     chkIdx <= 4'd0;
      else if (state == CHECK) chkIdx <= chkIdx + 4'd1;
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge iClk) begin
    if (doShift) shiftReg <= pattern[5:0];
    if (doStore) begin
      digitMem[digCnt + 4'd1] <= patDigit;
      if (isLeft) parityBits <= {parityBits[4:0], leftRes[4]};
    end
    if (state == PARITY) digitMem[0] <= firstRes[3:0];
`ifdef EAN13_CHECKSUM_EN
    if (state == PARITY)     acc <= 4'd0;
    else if (state == CHECK) acc <= accNext;
`endif
  end

endmodule
